mem_bus_unit: RTL
=================

# mem_bus_unit

Memory bus unit of the 6502 core, sitting directly downstream of the decode FSM. It executes the per-cycle memory command (`mem_mode`) the decoder issues against a byte-wide external memory with a ready handshake. It returns the fetched opcode/operand bytes in `MDR_curr`/`MDR_next`; `MDR_curr` is the byte the decoder consumes as `opcode`. Address selection (`ADDR_MUX`) happens upstream, so this block sees only the final 16-bit address.

## Interface
- `TIMEOUT_CYCLES`, default 16: wait-state limit before a bus access aborts. Used only with `BUS_TIMEOUT_EN`.
- `CLK` in 1: system clock; all state changes on its rising edge.
- `RESET` in 1: reset, asynchronous and active-low.
- `mem_mode` in `mem_mode_t`: command. Values are `MEM_KEEP`, `MEM_READ`, `MEM_READNEXT`, `MEM_WRITE`.
- `addr_in` in 16: access address, sampled with the command.
- `wdata` in 8: write data, sampled with `MEM_WRITE`.
- `mem_addr` out 16: address to external memory.
- `mem_rd` out 1: read strobe.
- `mem_wr` out 1: write strobe.
- `mem_wdata` out 8: write data to external memory.
- `mem_rdata` in 8: read data from external memory.
- `mem_ready` in 1: memory completes the current byte when high at a clock edge.
- `MDR_curr` out 8: first read byte (opcode or low operand).
- `MDR_next` out 8: second byte of `MEM_READNEXT` (high operand).
- `busy` out 1: command in progress; new commands are ignored.
- `done` out 1: one-cycle pulse when a command completes.
- `bus_err` out 1: sticky timeout flag. Exists only with `BUS_TIMEOUT_EN`.

## Operation
- States: `IDLE`, `ACC0`, `ACC1`, `FIN`.
- `IDLE`: when `mem_mode` is not `MEM_KEEP`, latch the command, `addr_in` and `wdata`, then go to `ACC0`. `MEM_KEEP` stays in `IDLE`.
- `ACC0`:
  - Drives `mem_addr` = latched address.
  - Drives `mem_rd` for reads or `mem_wr` for writes.
  - On an edge with `mem_ready`=1:
    - Reads: `MDR_curr` <= `mem_rdata`.
    - `MEM_READNEXT`: go to `ACC1`; otherwise go to `FIN`.
- `ACC1`: drives `mem_addr` = latched address + 1, modulo 2^16 (`FFFF` wraps to `0000`). On `mem_ready`, `MDR_next` <= `mem_rdata`, then go to `FIN`.
- `FIN`: `done`=1 for exactly one cycle, then `IDLE`.
- `busy`=1 in `ACC0`, `ACC1` and `FIN`.
- Commands presented while `busy` are dropped, not queued. The decoder holds its state until it sees `done`.
- Register retention:
  - `MEM_WRITE` leaves `MDR_curr`/`MDR_next` unchanged.
  - `MEM_READ` leaves `MDR_next` unchanged.
- Strobes are mutually exclusive. Both are low in `IDLE` and `FIN`.
- Reset (asynchronous, any state, including mid-access): state = `IDLE`; `mem_rd`, `mem_wr`, `busy`, `done` = 0; `mem_addr` = `0000`; `mem_wdata`, `MDR_curr`, `MDR_next` = `00`; `bus_err` = 0.
- Reset asserted in the same cycle as a command: reset wins and the command is lost.

## Timing
- All outputs are registered from state and latched data. There are no combinational paths from inputs to outputs.
- Command sampled at edge E:
  - Strobe is high during cycle E+1.
  - With zero wait states, `done` is high during cycle E+2 for `MEM_READ`/`MEM_WRITE`, and during cycle E+3 for `MEM_READNEXT`.
- Each wait cycle (`mem_ready`=0) adds one cycle to the access. `mem_addr` and the strobes stay stable throughout.
- `MDR_curr`/`MDR_next` are valid in the `done` cycle and hold until overwritten.
- Earliest back-to-back command: sampled in the cycle after `done`.

## Configuration
- Macro `BUS_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to `ACC0`/`ACC1`.
  - It increments on each edge with `mem_ready`=0.
  - When it reaches `TIMEOUT_CYCLES`, the access aborts: the byte being read loads `8'hFF`, `bus_err` sets (sticky until reset), and the FSM continues as if ready had arrived.
- Undefined:
  - The unit waits indefinitely.
  - No `bus_err` port and no counter logic.

## Structure
- `opcodes` package:
  - `mem_mode_t`, extended with `MEM_WRITE`.
  - New `bus_state_t` enum.
  - Constants `VEC_NMI`=`FFFA`, `VEC_RESET`=`FFFC`, `VEC_IRQ`=`FFFE`, used by the decoder's vector fetches through this unit.
- Sub-module `bus_timer`: the wait counter with terminal-count output. Instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Reset mid-`ACC0` with `mem_rd`=1: strobe and `busy` drop immediately on reset assertion; all outputs take their reset values; `MDR_curr`=`00`.
- `MEM_READ` at `8000`, memory `A9`, zero wait: `mem_rd` high in E+1, `done` in E+2, `MDR_curr`=`A9`, `MDR_next` unchanged.
- `MEM_READNEXT` at `FFFC`, memory `00`/`C0`, 2 wait states per byte: addresses `FFFC` then `FFFD`; `done` at E+7; `MDR_curr`=`00`, `MDR_next`=`C0`.
- `MEM_READNEXT` at `FFFF`: second access addresses `0000`.
- `MEM_WRITE` of `5A` to `0200`, with `MEM_READ` presented while `busy`: one `mem_wr` cycle with `mem_wdata`=`5A`; the read is ignored; `MDR` registers unchanged.
- `BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_ready` stuck low on `MEM_READ`: after 4 wait edges `MDR_curr`=`FF`, `bus_err`=1, `done` pulses once; `bus_err` stays 1 until reset.

Source files
------------

// File: rtl/mem_bus_unit_pkg.sv
// Shared types for the 6502 memory bus unit: bus commands, bus FSM states and vector addresses.
package opcodes;

  typedef enum logic [1:0] {
    MEM_KEEP     = 2'd0,
    MEM_READ     = 2'd1,
    MEM_READNEXT = 2'd2,
    MEM_WRITE    = 2'd3
  } mem_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    FIN  = 2'd3
  } bus_state_t;

  // Interrupt/reset vector locations, fetched by the decoder as MEM_READNEXT.
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [7:0] ABORT_BYTE = 8'hFF;

  function automatic logic is_read(input mem_mode_t mode);
    return (mode == MEM_READ) || (mode == MEM_READNEXT);
  endfunction

endpackage

// File: rtl/mem_bus_unit_bus_timer.sv
// Wait-state counter for one bus byte; tc flags the edge on which the LIMIT-th wait occurs.
module bus_timer #(
  parameter int LIMIT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  assign tc = inc && (count == CW'(LIMIT - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: runs one decoder memory command per handshake against a byte-wide ready-based bus.
// Optional wait-state timeout with sticky bus_err when BUS_TIMEOUT_EN is defined.
module mem_bus_unit
  import opcodes::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  mem_mode_t   mem_mode,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  MDR_curr,
  output logic [7:0]  MDR_next,
  output logic        busy,
  output logic        done
`ifdef BUS_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  bus_state_t  state, state_next;
  mem_mode_t   cmd_reg, cmd_next;
  logic [15:0] addr_next;
  logic        rd_next, wr_next, busy_next, done_next;
  logic [7:0]  wdata_next, mdr_curr_next, mdr_next_next;

  logic        ready_eff;
  logic [7:0]  byte_in;

`ifdef BUS_TIMEOUT_EN
  logic in_acc;
  logic timeout_tc;

  assign in_acc = (state == ACC0) || (state == ACC1);

  // Counter clears whenever the current byte finishes, so each byte gets a full budget.
  bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_bus_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (!in_acc || mem_ready || timeout_tc),
    .inc   (in_acc && !mem_ready),
    .tc    (timeout_tc)
  );

  assign ready_eff = mem_ready || timeout_tc;
  assign byte_in   = (mem_ready) ? mem_rdata : ABORT_BYTE;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus_err <= 1'b0;
    end else if (timeout_tc) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign ready_eff = mem_ready;
  assign byte_in   = mem_rdata;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cmd_reg   <= MEM_KEEP;
      mem_addr  <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'h00;
      MDR_curr  <= 8'h00;
      MDR_next  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_reg   <= cmd_next;
      mem_addr  <= addr_next;
      mem_rd    <= rd_next;
      mem_wr    <= wr_next;
      mem_wdata <= wdata_next;
      MDR_curr  <= mdr_curr_next;
      MDR_next  <= mdr_next_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next values for the registered outputs; every output is a flop, so
  // strobes/done are computed one state ahead of the cycle they appear in.
  always_comb begin
    state_next    = state;
    cmd_next      = cmd_reg;
    addr_next     = mem_addr;
    rd_next       = mem_rd;
    wr_next       = mem_wr;
    wdata_next    = mem_wdata;
    mdr_curr_next = MDR_curr;
    mdr_next_next = MDR_next;
    busy_next     = busy;
    done_next     = 1'b0;

    unique case (state)
      IDLE: begin
        if (mem_mode != MEM_KEEP) begin
          cmd_next   = mem_mode;
          addr_next  = addr_in;
          rd_next    = is_read(mem_mode);
          wr_next    = (mem_mode == MEM_WRITE);
          busy_next  = 1'b1;
          state_next = ACC0;
          if (mem_mode == MEM_WRITE) begin
            wdata_next = wdata;
          end
        end
      end
      ACC0: begin
        if (ready_eff) begin
          if (is_read(cmd_reg)) begin
            mdr_curr_next = byte_in;
          end
          if (cmd_reg == MEM_READNEXT) begin
            addr_next  = mem_addr + 16'd1;
            state_next = ACC1;
          end else begin
            rd_next    = 1'b0;
            wr_next    = 1'b0;
            done_next  = 1'b1;
            state_next = FIN;
          end
        end
      end
      ACC1: begin
        if (ready_eff) begin
          mdr_next_next = byte_in;
          rd_next       = 1'b0;
          done_next     = 1'b1;
          state_next    = FIN;
        end
      end
      FIN: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
